// File: rtl/lane_load_sequencer_if.sv
// +-- lane_load_sequencer_if : producer-side handshake plus lane-store load/dump port --+
// +-- rev 1.0                                                                          --+
`default_nettype none

interface lane_load_sequencer_if #(
  parameter int LANE_W = 64,
  parameter int IDX_W  = 5
);
  logic              start;
  logic              in_valid;
  logic [LANE_W-1:0] in_lane;
  logic              in_ready;
  logic              ldn;
  logic [IDX_W-1:0]  number;
  logic [LANE_W-1:0] nOut;
  logic              writeToFile;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  lane_cnt;

  modport slave (
    input  start, in_valid, in_lane,
    output in_ready, ldn, number, nOut, writeToFile, busy, done, lane_cnt
  );

  modport master (
    output start, in_valid, in_lane,
    input  in_ready, ldn, number, nOut, writeToFile, busy, done, lane_cnt
  );
endinterface

`default_nettype wire

// File: rtl/lane_load_sequencer.sv
// +-- lane_load_sequencer : loads one NUM_LANES image into the lane store, then dumps --+
// +-- rev 1.0                                                                          --+
`default_nettype none

module lane_load_sequencer #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25,
  parameter int IDX_W     = 5
) (
  input  wire                    clk,
  input  wire                    rst,
  lane_load_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DUMP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ldn_q, ldn_d;
  logic [IDX_W-1:0]  number_q, number_d;
  logic [LANE_W-1:0] nout_q, nout_d;
  logic              wtf_q, wtf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign bus.in_ready = (state_q == LOAD);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ldn_q    <= 1'b0;
      number_q <= '0;
      nout_q   <= '0;
      wtf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ldn_q    <= ldn_d;
      number_q <= number_d;
      nout_q   <= nout_d;
      wtf_q    <= wtf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobes (ldn, writeToFile, done) default low so each is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    ldn_d    = 1'b0;
    number_d = number_q;
    nout_d   = nout_q;
    wtf_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          ldn_d    = 1'b1;
          number_d = cnt_q;
          nout_d   = bus.in_lane;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == IDX_W'(NUM_LANES - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        wtf_d   = 1'b1;
        state_d = DUMP;
      end
      DUMP: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ldn         = ldn_q;
  assign bus.number      = number_q;
  assign bus.nOut        = nout_q;
  assign bus.writeToFile = wtf_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.lane_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_load_sequencer.sv
// +-- tb_lane_load_sequencer : directed self-checking bench for lane_load_sequencer --+
// +-- rev 1.0                                                                        --+
`default_nettype none

module tb_lane_load_sequencer;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int IDX_W     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  lane_load_sequencer_if #(.LANE_W(LANE_W), .IDX_W(IDX_W)) bus ();

  lane_load_sequencer #(
    .LANE_W   (LANE_W),
    .NUM_LANES(NUM_LANES),
    .IDX_W    (IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [LANE_W-1:0] lane(input int k);
    return 64'hA5A5_0000_0000_0000 | LANE_W'(k);
  endfunction

  // Outputs are registered; look at them 1 time unit after the edge that updated them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [78:0] obs;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_lane = '0;
    #2 rst = 1'b0;
    #1;
    obs = {bus.ldn, bus.number, bus.nOut, bus.writeToFile, bus.busy, bus.done, bus.lane_cnt, bus.in_ready};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_initial: got %h required 0", obs); end
    tick();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_lane = 64'h1234;
    tick();
    n_checks++;
    if (bus.ldn !== 1'b1) begin n_fail++; $display("FAIL reset_preload_ldn: got %b required 1", bus.ldn); end
    #3 rst = 1'b0;
    #1;
    obs = {bus.ldn, bus.number, bus.nOut, bus.writeToFile, bus.busy, bus.done, bus.lane_cnt, bus.in_ready};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_async_midcycle: got %h required 0", obs); end
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_full_burst();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.in_ready, bus.lane_cnt} !== {1'b1, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL burst_load_entry: got busy/rdy/cnt %b/%b/%0d required 1/1/0", bus.busy, bus.in_ready, bus.lane_cnt);
    end
    bus.in_valid = 1'b1; bus.in_lane = lane(0);
    for (int k = 0; k < NUM_LANES; k++) begin
      tick();
      n_checks++;
      if ({bus.ldn, bus.number, bus.nOut, bus.writeToFile} !== {1'b1, IDX_W'(k), lane(k), 1'b0}) begin
        n_fail++; $display("FAIL burst_lane%0d: got ldn=%b num=%0d nOut=%h wtf=%b required 1/%0d/%h/0",
                           k, bus.ldn, bus.number, bus.nOut, bus.writeToFile, k, lane(k));
      end
      n_checks++;
      if (bus.lane_cnt !== IDX_W'(k + 1)) begin
        n_fail++; $display("FAIL burst_cnt%0d: got %0d required %0d", k, bus.lane_cnt, k + 1);
      end
      bus.in_lane = lane(k + 1);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL burst_flush_ready: got %b required 0", bus.in_ready); end
    tick();
    n_checks++;
    if ({bus.ldn, bus.writeToFile, bus.done, bus.busy} !== 4'b0101) begin
      n_fail++; $display("FAIL burst_dump: got ldn/wtf/done/busy %b required 0101", {bus.ldn, bus.writeToFile, bus.done, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.writeToFile, bus.done, bus.busy, bus.lane_cnt} !== {3'b010, 5'd25}) begin
      n_fail++; $display("FAIL burst_done: got wtf/done/busy/cnt %b/%0d required 010/25", {bus.writeToFile, bus.done, bus.busy}, bus.lane_cnt);
    end
    tick();
    n_checks++;
    if ({bus.done, bus.lane_cnt} !== {1'b0, 5'd25}) begin
      n_fail++; $display("FAIL burst_after_done: got done=%b cnt=%0d required 0/25", bus.done, bus.lane_cnt);
    end
  endtask

  task automatic test_bubbles();
    int  exp_idx = 0;
    int  cyc     = 0;
    int  wtf_cnt = 0;
    bit  v       = 1'b1;
    bit  got_done = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_lane = lane(0);
    while (!got_done && cyc < 200) begin
      tick();
      cyc++;
      n_checks++;
      if (v && exp_idx < NUM_LANES) begin
        if ({bus.ldn, bus.number, bus.nOut} !== {1'b1, IDX_W'(exp_idx), lane(exp_idx)}) begin
          n_fail++; $display("FAIL bubble_lane%0d: got ldn=%b num=%0d nOut=%h", exp_idx, bus.ldn, bus.number, bus.nOut);
        end
        exp_idx++;
      end else if (bus.ldn !== 1'b0) begin
        n_fail++; $display("FAIL bubble_gap_cyc%0d: got ldn=%b required 0", cyc, bus.ldn);
      end
      if (bus.writeToFile) wtf_cnt++;
      if (bus.done) got_done = 1'b1;
      v = !v;
      bus.in_valid = v;
      bus.in_lane  = lane(exp_idx);
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (!got_done || cyc < 50) begin
      n_fail++; $display("FAIL bubble_done: got done=%b after %0d cycles required done after >=50", got_done, cyc);
    end
    n_checks++;
    if (wtf_cnt != 1) begin n_fail++; $display("FAIL bubble_wtf_count: got %0d required 1", wtf_cnt); end
    n_checks++;
    if (exp_idx != NUM_LANES) begin n_fail++; $display("FAIL bubble_lanes: got %0d required %0d", exp_idx, NUM_LANES); end
    tick();
  endtask

  task automatic test_start_while_busy();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_lane = lane(0);
    for (int k = 0; k < NUM_LANES; k++) begin
      tick();
      n_checks++;
      if ({bus.ldn, bus.number, bus.busy} !== {1'b1, IDX_W'(k), 1'b1}) begin
        n_fail++; $display("FAIL busy_start_lane%0d: got ldn=%b num=%0d busy=%b", k, bus.ldn, bus.number, bus.busy);
      end
      bus.start   = (k == 7);
      bus.in_lane = lane(k + 1);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL busy_first_done: got %b required 1", bus.done); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.in_ready, bus.lane_cnt, bus.done} !== {2'b11, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL busy_restart: got busy/rdy/cnt/done %b/%b/%0d/%b required 1/1/0/0", bus.busy, bus.in_ready, bus.lane_cnt, bus.done);
    end
    bus.in_valid = 1'b1; bus.in_lane = lane(0);
    for (int k = 0; k < NUM_LANES; k++) begin
      tick();
      if (k == 0) begin
        n_checks++;
        if ({bus.ldn, bus.number, bus.nOut} !== {1'b1, 5'd0, lane(0)}) begin
          n_fail++; $display("FAIL busy_restart_lane0: got ldn=%b num=%0d nOut=%h", bus.ldn, bus.number, bus.nOut);
        end
      end
      bus.in_lane = lane(k + 1);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL busy_second_done: got %b required 1", bus.done); end
    tick();
  endtask

  task automatic test_reset_midop();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_lane = lane(0);
    for (int k = 0; k <= 10; k++) begin
      tick();
      bus.in_lane = lane(k + 1);
    end
    n_checks++;
    if ({bus.ldn, bus.number} !== {1'b1, 5'd10}) begin
      n_fail++; $display("FAIL midop_lane10: got ldn=%b num=%0d required 1/10", bus.ldn, bus.number);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.ldn, bus.lane_cnt, bus.in_ready} !== '0) begin
      n_fail++; $display("FAIL midop_reset: got busy/ldn/cnt/rdy %b/%b/%0d/%b required 0", bus.busy, bus.ldn, bus.lane_cnt, bus.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 4) rst = 1'b1;
      n_checks++;
      if ({bus.writeToFile, bus.done, bus.busy, bus.ldn} !== 4'b0000) begin
        n_fail++; $display("FAIL midop_quiet%0d: got wtf/done/busy/ldn %b required 0000", c, {bus.writeToFile, bus.done, bus.busy, bus.ldn});
      end
    end
    bus.in_lane = lane(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if ({bus.ldn, bus.number, bus.nOut} !== {1'b1, 5'd0, lane(0)}) begin
      n_fail++; $display("FAIL midop_restart: got ldn=%b num=%0d nOut=%h required 1/0/%h", bus.ldn, bus.number, bus.nOut, lane(0));
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_idle_protection();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_lane = 64'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({bus.in_ready, bus.ldn, bus.busy} !== 3'b000) begin
        n_fail++; $display("FAIL idle_cyc%0d: got rdy/ldn/busy %b required 000", c, {bus.in_ready, bus.ldn, bus.busy});
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_bubbles();
    test_start_while_busy();
    test_reset_midop();
    test_idle_protection();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
